// File: rtl/status_pkg.sv
// status_pkg: shared definitions for the processor status word (PSW).
//   PSW layout: [0] C, [1] Z, [2] N, [3] V, [4] SLP, [7:5] PRI, [15:8] reserved (always 0).
//   Provides the flag index enum, bit-position localparams, the psw_t struct
//   and psw_clean(), which strips the reserved byte from raw write data.
package status_pkg;

  localparam int unsigned PSW_W   = 16;
  localparam int unsigned SLP_BIT = 4;
  localparam int unsigned PRI_LSB = 5;
  localparam int unsigned PRI_MSB = 7;

  typedef enum logic [1:0] {
    C = 2'd0,
    Z = 2'd1,
    N = 2'd2,
    V = 2'd3
  } flag_e;

  // Field order mirrors the bit layout above, MSB first.
  typedef struct packed {
    logic [7:0] rsvd;
    logic [2:0] pri;
    logic       slp;
    logic [3:0] flags;
  } psw_t;

  function automatic psw_t psw_clean(input logic [PSW_W-1:0] raw);
    psw_t p;
    p      = psw_t'(raw);
    p.rsvd = '0;
    return p;
  endfunction

endpackage

// File: rtl/status_register_if.sv
// status_register_if: bus bundle for status_register.
//   slave  modport: the PSW block (flag/PSW/stack requests in, status out).
//   master modport: whoever drives the requests and consumes the status.
//   Signal names match the original flat port list.
interface status_register_if;
  logic [3:0]  alu_flags;
  logic [3:0]  flag_wr_mask;
  logic [3:0]  cc_set;
  logic [3:0]  cc_clr;
  logic        psw_wr_en;
  logic [15:0] psw_in;
  logic        save_req;
  logic [2:0]  new_pri;
  logic        restore_req;
  logic        err_clr;
  logic [3:0]  status;
  logic [15:0] psw_out;
  logic [3:0]  depth;
  logic        stack_full;
  logic        stack_empty;
  logic        err_overflow;
  logic        err_underflow;

  modport slave (
    input  alu_flags, flag_wr_mask, cc_set, cc_clr, psw_wr_en, psw_in,
           save_req, new_pri, restore_req, err_clr,
    output status, psw_out, depth, stack_full, stack_empty,
           err_overflow, err_underflow
  );

  modport master (
    output alu_flags, flag_wr_mask, cc_set, cc_clr, psw_wr_en, psw_in,
           save_req, new_pri, restore_req, err_clr,
    input  status, psw_out, depth, stack_full, stack_empty,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/status_shadow_stack.sv
// status_shadow_stack: LIFO of saved PSWs with a single occupancy pointer.
//   clk, rst     clock, async active-high reset (clears the pointer only)
//   push, pop    requests; push ignored when full, pop ignored when empty
//   din          PSW to push
//   top          most recently pushed entry (undefined when empty)
//   depth        occupancy 0..SHADOW_DEPTH
//   full, empty  occupancy flags
module status_shadow_stack
  import status_pkg::*;
#(
  parameter int unsigned SHADOW_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  psw_t       din,
  output psw_t       top,
  output logic [3:0] depth,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

  psw_t       mem [SHADOW_DEPTH];
  logic [3:0] ptr;
  logic [3:0] top_ptr;

  always_comb begin
    top_ptr = ptr - 4'd1;
    top     = mem[top_ptr[AW-1:0]];
    depth   = ptr;
    full    = (ptr == 4'(SHADOW_DEPTH));
    empty   = (ptr == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 4'd1;
    end else if (pop && !empty) begin
      ptr <= ptr - 4'd1;
    end
  end

  // Storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/status_register.sv
// status_register: processor status word with flag update precedence and a
// shadow stack for exception entry/return.
//   clk, rst   clock, async active-high reset
//   bus        status_register_if.slave: ALU/SETCC/CLRCC flag updates, PSW
//              write, save/restore requests, err_clr; status, psw_out,
//              depth, stack_full/empty and sticky error outputs.
//   Macro STATUS_BYPASS_EN: when defined, status shows the next-state flags
//   combinationally; otherwise status is the registered flags.
module status_register
  import status_pkg::*;
#(
  parameter int unsigned SHADOW_DEPTH = 4,
  parameter logic [2:0]  RESET_PRI    = 3'd7
) (
  input logic               clk,
  input logic               rst,
  status_register_if.slave  bus
);

  psw_t       psw_q;
  psw_t       psw_d;
  psw_t       stack_top;
  logic [3:0] stack_depth;
  logic       full;
  logic       empty;
  logic       save_ok;
  logic       restore_ok;
  logic       ovf_set;
  logic       unf_set;
  logic       ovf_q;
  logic       unf_q;

  // Simultaneous save and restore cancel each other without raising an error.
  always_comb begin
    save_ok    = bus.save_req    & ~bus.restore_req & ~full;
    restore_ok = bus.restore_req & ~bus.save_req    & ~empty;
    ovf_set    = bus.save_req    & ~bus.restore_req &  full;
    unf_set    = bus.restore_req & ~bus.save_req    &  empty;
  end

  always_comb begin
    psw_d = psw_q;
    if (restore_ok) begin
      psw_d = stack_top;
    end else if (bus.psw_wr_en) begin
      psw_d = psw_clean(bus.psw_in);
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.cc_set[i]) begin
          psw_d.flags[i] = 1'b1;
        end else if (bus.cc_clr[i]) begin
          psw_d.flags[i] = 1'b0;
        end else if (bus.flag_wr_mask[i]) begin
          psw_d.flags[i] = bus.alu_flags[i];
        end
      end
    end
    // Exception entry overrides PRI/SLP on top of whichever update won above.
    if (save_ok) begin
      psw_d.pri = bus.new_pri;
      psw_d.slp = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psw_q <= '{rsvd: '0, pri: RESET_PRI, slp: 1'b0, flags: '0};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      psw_q <= psw_d;
      ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
      unf_q <= unf_set | (unf_q & ~bus.err_clr);
    end
  end

  status_shadow_stack #(
    .SHADOW_DEPTH (SHADOW_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (save_ok),
    .pop   (restore_ok),
    .din   (psw_q),
    .top   (stack_top),
    .depth (stack_depth),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
`ifdef STATUS_BYPASS_EN
    // Forced to 0 in reset so the bypass path cannot leak pending updates.
    bus.status = rst ? '0 : psw_d.flags;
`else
    bus.status = psw_q.flags;
`endif
    bus.psw_out       = psw_q;
    bus.depth         = stack_depth;
    bus.stack_full    = full;
    bus.stack_empty   = empty;
    bus.err_overflow  = ovf_q;
    bus.err_underflow = unf_q;
  end

endmodule
